// File: rtl/reg_bank_pkg.sv
// Shared definitions for the register bank arbiter slice: default bank
// geometry, the requester id type and the commit-stage record layout.
package reg_bank_pkg;

  localparam int REG_NREGS = 4;
  localparam int REG_WIDTH = 4;

  typedef logic reqId_t;

  typedef struct packed {
    logic                         valid;
    logic [$clog2(REG_NREGS)-1:0] addr;
    logic [REG_WIDTH-1:0]         data;
  } commit_t;

endpackage

// File: rtl/reg_bank_arbiter_if.sv
// Bus bundle between the two write requesters / reader and the bank.
// master = the producers and reader side, slave = the bank controller.
interface reg_bank_arbiter_if
  import reg_bank_pkg::*;
#(
  parameter int NREGS = REG_NREGS,
  parameter int WIDTH = REG_WIDTH
);
  localparam int AW = $clog2(NREGS);

  logic             req0;
  logic [AW-1:0]    addr0;
  logic [WIDTH-1:0] data0;
  logic             gnt0;
  logic             req1;
  logic [AW-1:0]    addr1;
  logic [WIDTH-1:0] data1;
  logic             gnt1;
  logic [AW-1:0]    raddr;
  logic [WIDTH-1:0] rdata;
  logic             wr_pending;
  reqId_t           last_gnt;

  modport master (
    output req0, addr0, data0, req1, addr1, data1, raddr,
    input  gnt0, gnt1, rdata, wr_pending, last_gnt
  );

  modport slave (
    input  req0, addr0, data0, req1, addr1, data1, raddr,
    output gnt0, gnt1, rdata, wr_pending, last_gnt
  );

endinterface

// File: rtl/reg_bank_arbiter_reg_en_sr.sv
// Generic WIDTH-bit storage register with load enable and synchronous
// active-high clear. Used for every bank entry and for the commit data.
module reg_en_sr #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] data_q;

  // Clear on reset, otherwise load only when enabled
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
    end else if (en_i) begin
      data_q <= d_i;
    end
  end

  assign q_o = data_q;

endmodule

// File: rtl/reg_bank_arbiter.sv
// Shared register bank controller: two write requesters arbitrated
// round-robin into a single commit stage that writes the bank one cycle
// after the grant, plus one combinational read port.
// Optional feature macro: REG_BANK_BYPASS_EN forwards the commit-stage
// data to the read port when the read address matches the pending write.
module reg_bank_arbiter
  import reg_bank_pkg::*;
#(
  parameter int NREGS = REG_NREGS,
  parameter int WIDTH = REG_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  reg_bank_arbiter_if.slave  bus
);

  localparam int AW = $clog2(NREGS);

  typedef struct packed {
    logic             valid;
    logic [AW-1:0]    addr;
    logic [WIDTH-1:0] data;
  } commitStage_t;

  logic             gnt0;
  logic             gnt1;
  reqId_t           prio_q;
  reqId_t           prio_d;
  reqId_t           lastGnt_q;
  reqId_t           lastGnt_d;
  commitStage_t     commit_d;
  logic             commitV_q;
  logic [AW-1:0]    commitAddr_q;
  logic [WIDTH-1:0] commitData_q;
  logic [WIDTH-1:0] bank_q [NREGS];

  // Grant: a lone requester always wins, a tie goes to prio; nothing in reset
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      if (bus.req0 && (!bus.req1 || prio_q == 1'b0)) begin
        gnt0 = 1'b1;
      end else if (bus.req1) begin
        gnt1 = 1'b1;
      end
    end
  end

  // Winner's address/data feed the commit stage; no grant empties it
  always_comb begin
    commit_d = '0;
    if (gnt0) begin
      commit_d.valid = 1'b1;
      commit_d.addr  = bus.addr0;
      commit_d.data  = bus.data0;
    end else if (gnt1) begin
      commit_d.valid = 1'b1;
      commit_d.addr  = bus.addr1;
      commit_d.data  = bus.data1;
    end
  end

  // Any grant hands priority to the other requester and records the winner
  always_comb begin
    prio_d    = prio_q;
    lastGnt_d = lastGnt_q;
    if (gnt0) begin
      prio_d    = 1'b1;
      lastGnt_d = 1'b0;
    end else if (gnt1) begin
      prio_d    = 1'b0;
      lastGnt_d = 1'b1;
    end
  end

  // Arbitration state and commit control; reset drops any pending write
  always_ff @(posedge clk) begin
    if (rst) begin
      prio_q       <= 1'b0;
      lastGnt_q    <= 1'b0;
      commitV_q    <= 1'b0;
      commitAddr_q <= '0;
    end else begin
      prio_q       <= prio_d;
      lastGnt_q    <= lastGnt_d;
      commitV_q    <= commit_d.valid;
      commitAddr_q <= commit_d.addr;
    end
  end

  reg_en_sr #(.WIDTH(WIDTH)) uCommitData (
    .clk  (clk),
    .rst  (rst),
    .en_i (commit_d.valid),
    .d_i  (commit_d.data),
    .q_o  (commitData_q)
  );

  for (genvar i = 0; i < NREGS; i++) begin : gBank
    reg_en_sr #(.WIDTH(WIDTH)) uEntry (
      .clk  (clk),
      .rst  (rst),
      .en_i (commitV_q && (commitAddr_q == AW'(i))),
      .d_i  (commitData_q),
      .q_o  (bank_q[i])
    );
  end

  assign bus.gnt0       = gnt0;
  assign bus.gnt1       = gnt1;
  assign bus.wr_pending = commitV_q;
  assign bus.last_gnt   = lastGnt_q;

`ifdef REG_BANK_BYPASS_EN
  assign bus.rdata = (commitV_q && (bus.raddr == commitAddr_q)) ? commitData_q
                                                                : bank_q[bus.raddr];
`else
  assign bus.rdata = bank_q[bus.raddr];
`endif

endmodule
